// File: rtl/sram_rd_responder.sv
// Arbitrates several read-port hosts onto one banked SRAM, one beat per cycle.
// Bursts lock to their owner until rlast; read data returns RD_LAT+1 cycles after acceptance.
module sram_rd_responder #(
    parameter int unsigned NUM_PORTS    = 2,
    parameter int unsigned BANK_CNT_LG2 = 2,
    parameter int unsigned DEPTH_LG2    = 10,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic [NUM_PORTS-1:0]                            req_i,
    input  logic [NUM_PORTS-1:0][BANK_CNT_LG2-1:0]          rid_i,
    input  logic [NUM_PORTS-1:0][DEPTH_LG2-1:0]             addr_i,
    input  logic [NUM_PORTS-1:0]                            reb_i,
    input  logic [NUM_PORTS-1:0]                            rlast_i,
    output logic [NUM_PORTS-1:0]                            ack_o,
    output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]            rdata_o,
    output logic [NUM_PORTS-1:0]                            rvalid_o,
    output logic [(2**BANK_CNT_LG2)-1:0]                    mem_reb_o,
    output logic [DEPTH_LG2-1:0]                            mem_addr_o,
    input  logic [(2**BANK_CNT_LG2)-1:0][DATA_WIDTH-1:0]    mem_rdata_i
);

    localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {S_IDLE, S_LOCKED} state_e;

    state_e                               state_q, state_d;
    logic [PW-1:0]                        owner_q, owner_d;
    logic [PW-1:0]                        rr_q, rr_d;
    logic [PW:0]                          cand;
    logic                                 hit_c;
    logic [PW-1:0]                        win_c;

    logic [RD_LAT-1:0]                    vld_q;
    logic [RD_LAT-1:0][PW-1:0]            pport_q;
    logic [RD_LAT-1:0][BANK_CNT_LG2-1:0]  prid_q;

    // Grant selection, SRAM strobe and next arbiter state, all combinational on the accept path.
    always_comb begin
        ack_o      = '0;
        mem_reb_o  = '1;
        mem_addr_o = '0;
        hit_c      = 1'b0;
        win_c      = '0;
        cand       = '0;
        state_d    = state_q;
        owner_d    = owner_q;
        rr_d       = rr_q;

        if (state_q == S_LOCKED) begin
            if (req_i[owner_q]) begin
                hit_c = 1'b1;
                win_c = owner_q;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                cand = {1'b0, rr_q} + (PW+1)'(i);
                if (cand >= (PW+1)'(NUM_PORTS)) begin
                    cand = cand - (PW+1)'(NUM_PORTS);
                end
                if (!hit_c && req_i[cand[PW-1:0]]) begin
                    hit_c = 1'b1;
                    win_c = cand[PW-1:0];
                end
            end
        end

        if (hit_c) begin
            ack_o[win_c] = 1'b1;
            if (!reb_i[win_c]) begin
                mem_reb_o[rid_i[win_c]] = 1'b0;
                mem_addr_o              = addr_i[win_c];
            end
            // A single-beat burst never enters LOCKED.
            if (rlast_i[win_c]) begin
                state_d = S_IDLE;
                rr_d    = (win_c == PW'(NUM_PORTS - 1)) ? '0 : win_c + PW'(1);
            end else begin
                state_d = S_LOCKED;
                owner_d = win_c;
            end
        end
    end

    // Arbiter state, return pipeline and registered read-data outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= '0;
            rr_q     <= '0;
            vld_q    <= '0;
            pport_q  <= '0;
            prid_q   <= '0;
            rvalid_o <= '0;
            rdata_o  <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            vld_q[0]   <= hit_c && !reb_i[win_c];
            pport_q[0] <= win_c;
            prid_q[0]  <= rid_i[win_c];
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld_q[i]   <= vld_q[i-1];
                pport_q[i] <= pport_q[i-1];
                prid_q[i]  <= prid_q[i-1];
            end
            rvalid_o <= '0;
            if (vld_q[RD_LAT-1]) begin
                rvalid_o[pport_q[RD_LAT-1]] <= 1'b1;
                rdata_o[pport_q[RD_LAT-1]]  <= mem_rdata_i[prid_q[RD_LAT-1]];
            end
        end
    end

endmodule
